// File: rtl/mc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : mc_fetch_unit
// Brief    : Architectural state stage of the multi-cycle MIPS datapath.
//            Holds PC, IR, MDR, A/B operand registers and ALUOut, selects
//            the next PC and the shared memory address, and returns the
//            opcode field to the main control decoder.
// Revision : 1.0 - initial release
// ============================================================================
module mc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,        // asynchronous, active-low
    input  logic        PCWrite,
    input  logic        Branch,
    input  logic [1:0]  PCSrc,
    input  logic        IorD,
    input  logic        IRWrite,
    input  logic        Zero,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ReadData,
    input  logic [31:0] RD1,
    input  logic [31:0] RD2,
    output logic [31:0] PC,
    output logic [31:0] Adr,
    output logic [31:0] Instr,
    output logic [5:0]  OPCode,
    output logic [31:0] Data,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [31:0] ALUOut,
    output logic [31:0] fetch_count,
    output logic        pc_misalign
);

    localparam logic [1:0] c_SRC_ALURESULT = 2'b00;
    localparam logic [1:0] c_SRC_ALUOUT    = 2'b01;
    localparam logic [1:0] c_SRC_JUMP      = 2'b10;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_data;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_aluout;
    logic [31:0] r_fetch_count;
    logic        r_pc_misalign;

    logic        w_pc_en;
    logic [31:0] w_next_pc;
    logic        w_next_aligned;
    logic        w_pc_load;
    logic        w_misalign_hit;

    // Unconditional or zero-qualified branch write of the PC.
    assign w_pc_en = PCWrite | (Branch & Zero);

    // Next-PC mux; any other select (hold, or unknown) keeps the current PC,
    // so an undriven PCSrc can never leak into the PC register.
    always_comb begin
        w_next_pc = r_pc;
        case (PCSrc)
            c_SRC_ALURESULT: w_next_pc = ALUResult;
            c_SRC_ALUOUT:    w_next_pc = r_aluout;
            c_SRC_JUMP:      w_next_pc = {r_pc[31:28], r_instr[25:0], 2'b00};
            default:         w_next_pc = r_pc;
        endcase
    end

    // A misaligned target is dropped and flagged instead of being loaded.
    assign w_next_aligned = (w_next_pc[1:0] == 2'b00);
    assign w_pc_load      = w_pc_en & w_next_aligned;
    assign w_misalign_hit = w_pc_en & ~w_next_aligned;

    // Program counter with aligned-only update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else if (w_pc_load) begin
            r_pc <= w_next_pc;
        end
    end

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc_misalign <= 1'b0;
        end else if (w_misalign_hit) begin
            r_pc_misalign <= 1'b1;
        end
    end

    // Instruction register and fetch counter advance together on IRWrite.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr       <= 32'h0;
            r_fetch_count <= 32'h0;
        end else if (IRWrite) begin
            r_instr       <= ReadData;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    // Free-running pipeline registers sampled every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data   <= 32'h0;
            r_a      <= 32'h0;
            r_b      <= 32'h0;
            r_aluout <= 32'h0;
        end else begin
            r_data   <= ReadData;
            r_a      <= RD1;
            r_b      <= RD2;
            r_aluout <= ALUResult;
        end
    end

    assign Adr         = IorD ? r_aluout : r_pc;
    assign PC          = r_pc;
    assign Instr       = r_instr;
    assign OPCode      = r_instr[31:26];
    assign Data        = r_data;
    assign A           = r_a;
    assign B           = r_b;
    assign ALUOut      = r_aluout;
    assign fetch_count = r_fetch_count;
    assign pc_misalign = r_pc_misalign;

endmodule
`default_nettype wire

// File: tb/tb_mc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_fetch_unit
// Brief    : Directed self-checking bench for mc_fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_fetch_unit;

    logic        clk;
    logic        reset;
    logic        PCWrite;
    logic        Branch;
    logic [1:0]  PCSrc;
    logic        IorD;
    logic        IRWrite;
    logic        Zero;
    logic [31:0] ALUResult;
    logic [31:0] ReadData;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] PC;
    logic [31:0] Adr;
    logic [31:0] Instr;
    logic [5:0]  OPCode;
    logic [31:0] Data;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] ALUOut;
    logic [31:0] fetch_count;
    logic        pc_misalign;

    int total;
    int bad;

    mc_fetch_unit #(.RESET_PC(32'h0000_0040)) dut (
        .clk         (clk),
        .reset       (reset),
        .PCWrite     (PCWrite),
        .Branch      (Branch),
        .PCSrc       (PCSrc),
        .IorD        (IorD),
        .IRWrite     (IRWrite),
        .Zero        (Zero),
        .ALUResult   (ALUResult),
        .ReadData    (ReadData),
        .RD1         (RD1),
        .RD2         (RD2),
        .PC          (PC),
        .Adr         (Adr),
        .Instr       (Instr),
        .OPCode      (OPCode),
        .Data        (Data),
        .A           (A),
        .B           (B),
        .ALUOut      (ALUOut),
        .fetch_count (fetch_count),
        .pc_misalign (pc_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One rising edge; returns at the following falling edge for sampling.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        PCWrite = 1'b0; Branch = 1'b0; PCSrc = 2'b00; IorD = 1'b0;
        IRWrite = 1'b1; Zero = 1'b0;
        ALUResult = 32'h0000_0004; ReadData = 32'hDEAD_BEEF;
        RD1 = 32'h0; RD2 = 32'h0;

        // Reset held low across edges with IRWrite active.
        step();
        step();
        check("rst_pc",   PC,                  32'h0000_0040);
        check("rst_ir",   Instr,               32'h0);
        check("rst_cnt",  fetch_count,         32'h0);
        check("rst_mis",  {31'h0, pc_misalign}, 32'h0);
        check("rst_aluo", ALUOut,              32'h0);
        check("rst_data", Data,                32'h0);

        // Release, then first edge is a fetch.
        reset = 1'b1;
        IRWrite = 1'b1; PCWrite = 1'b1; PCSrc = 2'b00; IorD = 1'b0;
        ReadData = 32'h8C08_0004; ALUResult = 32'h0000_0044;
        RD1 = 32'h0000_0011; RD2 = 32'h0000_0022;
        #1;
        check("pre_adr", Adr, 32'h0000_0040);
        step();
        check("f_ir",   Instr,              32'h8C08_0004);
        check("f_op",   {26'h0, OPCode},    32'h0000_0023);
        check("f_pc",   PC,                 32'h0000_0044);
        check("f_cnt",  fetch_count,        32'h1);
        check("f_adr",  Adr,                32'h0000_0044);
        check("f_data", Data,               32'h8C08_0004);
        check("f_a",    A,                  32'h0000_0011);
        check("f_b",    B,                  32'h0000_0022);
        check("f_aluo", ALUOut,             32'h0000_0044);

        // Load ALUOut with branch target.
        IRWrite = 1'b0; PCWrite = 1'b0; ALUResult = 32'h0000_0100;
        step();
        check("b_aluo", ALUOut, 32'h0000_0100);
        IorD = 1'b1;
        #1;
        check("b_adr_io", Adr, 32'h0000_0100);
        IorD = 1'b0;

        // Branch not taken.
        PCSrc = 2'b01; Branch = 1'b1; Zero = 1'b0; ALUResult = 32'h0000_0100;
        step();
        check("bnt_pc", PC, 32'h0000_0044);

        // Branch taken: target comes from ALUOut, not ALUResult.
        Zero = 1'b1; ALUResult = 32'h0000_0000;
        step();
        check("bt_pc", PC, 32'h0000_0100);
        Branch = 1'b0; Zero = 1'b0;

        // Fetch a jump instruction with PC+4 = 0x1000_0008.
        IRWrite = 1'b1; PCWrite = 1'b1; PCSrc = 2'b00;
        ReadData = 32'h0800_0010; ALUResult = 32'h1000_0008;
        step();
        check("j_fpc", PC,          32'h1000_0008);
        check("j_cnt", fetch_count, 32'h2);

        // Jump.
        IRWrite = 1'b0; PCSrc = 2'b10; ALUResult = 32'h5555_0000;
        step();
        check("j_pc", PC, 32'h1000_0040);

        // Misaligned write is blocked and flagged.
        PCSrc = 2'b00; ALUResult = 32'h0000_0046;
        step();
        check("m_pc",  PC,                   32'h1000_0040);
        check("m_mis", {31'h0, pc_misalign}, 32'h1);

        // No enable with unknown select: PC holds, flag sticks.
        PCWrite = 1'b0; Branch = 1'b0; PCSrc = 2'bxx; ALUResult = 32'h0000_0200;
        for (int i = 0; i < 10; i++) begin
            step();
            check("x_pc",  PC,                   32'h1000_0040);
            check("x_mis", {31'h0, pc_misalign}, 32'h1);
        end

        // Aligned write still works; flag remains set.
        PCWrite = 1'b1; PCSrc = 2'b00; ALUResult = 32'h0000_0080;
        step();
        check("a_pc",  PC,                   32'h0000_0080);
        check("a_mis", {31'h0, pc_misalign}, 32'h1);

        // Counter wrap.
        PCWrite = 1'b0;
        force dut.r_fetch_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_fetch_count;
        IRWrite = 1'b1; ReadData = 32'h1234_5678;
        RD1 = 32'h0000_0AAA; RD2 = 32'h0000_0BBB; ALUResult = 32'h0000_0CCC;
        step();
        check("w_cnt",  fetch_count,          32'h0);
        check("w_ir",   Instr,                32'h1234_5678);
        check("w_pc",   PC,                   32'h0000_0080);
        check("w_mis",  {31'h0, pc_misalign}, 32'h1);
        check("w_a",    A,                    32'h0000_0AAA);
        check("w_aluo", ALUOut,               32'h0000_0CCC);

        // One more fetch, then asynchronous reset between edges.
        step();
        check("pre_cnt", fetch_count, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_pc",  PC,                   32'h0000_0040);
        check("ar_ir",  Instr,                32'h0);
        check("ar_cnt", fetch_count,          32'h0);
        check("ar_mis", {31'h0, pc_misalign}, 32'h0);
        check("ar_a",   A,                    32'h0);

        // Release and confirm the first edge behaves normally.
        @(negedge clk);
        reset = 1'b1;
        IRWrite = 1'b1; PCWrite = 1'b1; PCSrc = 2'b00;
        ReadData = 32'hAC09_0008; ALUResult = 32'h0000_0044;
        step();
        check("r2_pc",  PC,          32'h0000_0044);
        check("r2_ir",  Instr,       32'hAC09_0008);
        check("r2_cnt", fetch_count, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
